fifo_v4_thresh: RTL



---
 rtl/fifo_v4_pkg.sv | 22 ++
 rtl/fifo_v4_ptr.sv | 24 ++
 rtl/fifo_v4_thresh.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fifo_v4_pkg.sv
// fifo_v4_pkg: helpers shared by fifo_v4_thresh and its pointer sub-module.
// Provides pointer width derivation, pointer increment-with-wrap and even parity.
package fifo_v4_pkg;

  // Widest payload the parity helper covers; narrower payloads are zero-extended,
  // which leaves the parity unchanged.
  localparam int unsigned PARITY_MAX_WIDTH = 1024;

  function automatic int unsigned calc_addr_depth(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Wraps at depth-1 rather than at a power of two, so any depth works.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/fifo_v4_ptr.sv
// fifo_v4_ptr: FIFO read/write pointer with wrap at DEPTH-1, sync reset/flush.
module fifo_v4_ptr
  import fifo_v4_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          en,
  output logic [AW-1:0] ptr
);

  // advance on enable, clear on reset or flush
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= AW'(ptr_next(32'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/fifo_v4_thresh.sv
// fifo_v4_thresh: synchronous FIFO with programmable almost-full/almost-empty
// thresholds, full-width occupancy, push-while-full-with-pop, sticky
// overflow/underflow flags, optional fall-through and DEPTH=0 pass-through.
// Optional feature macro FIFO_V4_PARITY_EN: store an even-parity bit per entry
// and raise a sticky parity_err_o when a popped entry fails the check.
module fifo_v4_thresh
  import fifo_v4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int          AF_THRESH    = int'(DEPTH) - 1,
  parameter int          AE_THRESH    = 1,
  parameter int unsigned ADDR_DEPTH   = calc_addr_depth(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_DEPTH:0]   usage_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic                  parity_err_o
);

  localparam int unsigned CW = ADDR_DEPTH + 1;

  logic unused_testmode;
  assign unused_testmode = testmode_i;

  logic push_acc, pop_acc;
  logic ovf_q, udf_q;

  // Same acceptance rule covers DEPTH=0, where full_o is ~pop_i.
  assign push_acc    = push_i && (!full_o || (pop_i && !FALL_THROUGH));
  assign pop_acc     = pop_i && !empty_o;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

  // sticky error flags, cleared only by reset or flush
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push_i && !push_acc) ovf_q <= 1'b1;
      if (pop_i && empty_o)    udf_q <= 1'b1;
    end
  end

  if (DEPTH == 0) begin : g_pass
    assign data_o         = data_i;
    assign empty_o        = ~push_i;
    assign full_o         = ~pop_i;
    assign usage_o        = '0;
    assign almost_full_o  = 1'b0;
    assign almost_empty_o = 1'b0;
    assign parity_err_o   = 1'b0;
  end else begin : g_fifo
    if (AF_THRESH > int'(DEPTH)) begin : g_af_chk
      $error("fifo_v4_thresh: AF_THRESH exceeds DEPTH");
    end
    if (AE_THRESH > int'(DEPTH)) begin : g_ae_chk
      $error("fifo_v4_thresh: AE_THRESH exceeds DEPTH");
    end

`ifdef FIFO_V4_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned EW = DATA_WIDTH + PAR_W;

    logic [EW-1:0]         mem [DEPTH];
    logic [EW-1:0]         entry_in;
    logic [EW-1:0]         head;
    logic [ADDR_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  count_zero;
    logic                  bypass;
    logic                  do_write, do_read;

    assign count_zero = (count == '0);
    // Fall-through push+pop on an empty FIFO hands data straight across:
    // nothing is stored and pointers/count stay put.
    assign bypass     = FALL_THROUGH && count_zero && push_i && pop_i;
    assign do_write   = push_acc && !bypass;
    assign do_read    = pop_acc && !bypass;
    assign head       = mem[rd_ptr];

    assign full_o         = (count == CW'(DEPTH));
    assign empty_o        = FALL_THROUGH ? (count_zero && !push_i) : count_zero;
    assign data_o         = (FALL_THROUGH && count_zero) ? data_i : head[DATA_WIDTH-1:0];
    assign usage_o        = count;
    assign almost_full_o  = (int'(count) >= AF_THRESH);
    assign almost_empty_o = (int'(count) <= AE_THRESH);

    fifo_v4_ptr #(.DEPTH(DEPTH), .AW(ADDR_DEPTH)) u_wr_ptr (
      .clk(clk_i), .rst(rst_i), .flush(flush_i), .en(do_write), .ptr(wr_ptr)
    );

    fifo_v4_ptr #(.DEPTH(DEPTH), .AW(ADDR_DEPTH)) u_rd_ptr (
      .clk(clk_i), .rst(rst_i), .flush(flush_i), .en(do_read), .ptr(rd_ptr)
    );

    // storage: cleared by reset only, flush leaves stale contents in place
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (do_write) begin
        mem[wr_ptr] <= entry_in;
      end
    end

    // occupancy: unchanged when a push and a pop land together
    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        count <= '0;
      end else if (do_write && !do_read) begin
        count <= count + CW'(1);
      end else if (do_read && !do_write) begin
        count <= count - CW'(1);
      end
    end

`ifdef FIFO_V4_PARITY_EN
    logic par_q;
    assign entry_in     = {even_parity(PARITY_MAX_WIDTH'(data_i)), data_i};
    assign parity_err_o = par_q;

    // sticky parity check on every pop served from storage
    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        par_q <= 1'b0;
      end else if (do_read &&
                   (even_parity(PARITY_MAX_WIDTH'(head[DATA_WIDTH-1:0])) != head[EW-1])) begin
        par_q <= 1'b1;
      end
    end
`else
    assign entry_in     = data_i;
    assign parity_err_o = 1'b0;
`endif
  end

endmodule
